// File: rtl/mux_stage_pkg.sv
// Shared defaults and skid state encoding for the mux_stage block.
// No logic; type and constant definitions only.
// Used by mux_n and mux_stage (skid build uses the state enum).
package mux_stage_pkg;

  localparam int MUX_STAGE_W_DEFAULT = 32;
  localparam int MUX_STAGE_N_DEFAULT = 4;

  // Occupancy of the output register plus the one-entry skid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_t;

endpackage

// File: rtl/mux_n.sv
// Purpose: N-way W-bit combinational selector with out-of-range flag.
// Latency: zero cycles, purely combinational.
// Backpressure: none; the caller decides when the result is captured.
module mux_n import mux_stage_pkg::*; #(
  parameter int W = MUX_STAGE_W_DEFAULT,
  parameter int N = MUX_STAGE_N_DEFAULT,
  localparam int SELW = $clog2(N)
) (
  input  logic [N*W-1:0]  in_data,
  input  logic [SELW-1:0] sel,
  output logic [W-1:0]    out,
  output logic            sel_err
);

  // Select input k; an index with no matching input gives zero and flags it.
  always_comb begin
    out     = '0;
    sel_err = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (sel == SELW'(k)) begin
        out     = in_data[k*W +: W];
        sel_err = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_stage.sv
// Purpose: N-way selector feeding a registered valid/ready output stage.
// Latency: one cycle from accept edge to out_*; one beat per cycle when out_ready=1.
// Backpressure: output held while stalled; MUX_STAGE_SKID_EN adds a skid entry and registers in_ready.
module mux_stage import mux_stage_pkg::*; #(
  parameter int W = MUX_STAGE_W_DEFAULT,
  parameter int N = MUX_STAGE_N_DEFAULT,
  localparam int SELW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N*W-1:0]  in_data,
  input  logic [SELW-1:0] sel,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            flush,
  output logic [W-1:0]    out_data,
  output logic            out_sel_err,
  output logic            out_valid,
  input  logic            out_ready
);

  logic [W-1:0] mux_out;
  logic         mux_err;

  mux_n #(.W(W), .N(N)) u_mux (
    .in_data (in_data),
    .sel     (sel),
    .out     (mux_out),
    .sel_err (mux_err)
  );

`ifdef MUX_STAGE_SKID_EN

  skid_state_t  state_q, state_d;
  logic [W-1:0] skid_data;
  logic         skid_err;
  logic         ready_q;
  logic         accept, emit;
  logic         load_out, load_skid, pop_skid;

  assign in_ready  = ready_q;
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid && ready_q;
  assign emit      = out_valid && out_ready;

  // Next occupancy and which register loads on this edge; flush wins over everything.
  always_comb begin
    state_d   = state_q;
    load_out  = 1'b0;
    load_skid = 1'b0;
    pop_skid  = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (accept) begin
          state_d  = ONE;
          load_out = 1'b1;
        end
        ONE: if (accept && emit) begin
          load_out = 1'b1;
        end else if (accept) begin
          state_d   = TWO;
          load_skid = 1'b1;
        end else if (emit) begin
          state_d = EMPTY;
        end
        TWO: if (emit) begin
          state_d  = ONE;
          pop_skid = 1'b1;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Occupancy register; in_ready is precomputed so it never depends on out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != TWO);
    end
  end

  // Output and skid data registers; flush suppresses loads so out_data keeps its value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data    <= '0;
      out_sel_err <= 1'b0;
      skid_data   <= '0;
      skid_err    <= 1'b0;
    end else begin
      if (load_out) begin
        out_data    <= mux_out;
        out_sel_err <= mux_err;
      end else if (pop_skid) begin
        out_data    <= skid_data;
        out_sel_err <= skid_err;
      end
      if (load_skid) begin
        skid_data <= mux_out;
        skid_err  <= mux_err;
      end
    end
  end

`else

  logic accept;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Single output register: load on accept, drain on emit, flush drops the beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_sel_err <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_data    <= mux_out;
      out_sel_err <= mux_err;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`endif

endmodule

// File: tb/tb_mux_stage.sv
// Directed bench for mux_stage: reset, streaming, backpressure, flush, out-of-range select.
// Expected values are hand-computed; backpressure rows depend on MUX_STAGE_SKID_EN.
// Prints one summary line and finishes.
module tb_mux_stage;

`ifdef MUX_STAGE_SKID_EN
  localparam logic SKID = 1'b1;
`else
  localparam logic SKID = 1'b0;
`endif

  localparam logic [31:0] A0 = 32'hA0, A1 = 32'hA1, A2 = 32'hA2, A3 = 32'hA3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] in_data;
  logic [1:0]   sel;
  logic         in_valid, in_ready, flush, out_sel_err, out_valid, out_ready;
  logic [31:0]  out_data;

  logic [95:0]  in_data3;
  logic [1:0]   sel3;
  logic         in_valid3, in_ready3, flush3, out_sel_err3, out_valid3, out_ready3;
  logic [31:0]  out_data3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_stage dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .sel(sel),
    .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .out_data(out_data), .out_sel_err(out_sel_err),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  mux_stage #(.W(32), .N(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .sel(sel3),
    .in_valid(in_valid3), .in_ready(in_ready3), .flush(flush3),
    .out_data(out_data3), .out_sel_err(out_sel_err3),
    .out_valid(out_valid3), .out_ready(out_ready3)
  );

  typedef struct {
    logic [1:0]  sel;
    logic        v;
    logic        ordy;
    logic        ir_pre;  // in_ready after driving, before the edge
    logic        ov;      // out_valid after the edge
    logic        ir;      // in_ready after the edge
    logic [31:0] od;      // out_data after the edge, checked when ov=1
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_data   = {A3, A2, A1, A0};
    sel       = 2'd0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    in_data3  = {32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    sel3      = 2'd0;
    in_valid3 = 1'b0;
    flush3    = 1'b0;
    out_ready3 = 1'b1;

    // Streaming, then 3 stalled cycles with in_valid=1, then release with in_valid=0.
    tbl[0] = '{2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, A0};
    tbl[1] = '{2'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, A1};
    tbl[2] = '{2'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, A2};
    tbl[3] = '{2'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, A3};
    tbl[4] = '{2'd0, 1'b1, 1'b0, SKID, 1'b1, 1'b0, A3};
    tbl[5] = '{2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, A3};
    tbl[6] = '{2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, A3};
    tbl[7] = '{2'd0, 1'b0, 1'b1, !SKID, SKID, 1'b1, A0};
    tbl[8] = '{2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, A0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_data", out_data, 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_sel_err", 32'(out_sel_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven streaming and backpressure
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      sel       = tbl[i].sel;
      in_valid  = tbl[i].v;
      out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("row%0d in_ready_pre", i), 32'(in_ready), 32'(tbl[i].ir_pre));
      @(posedge clk);
      #1;
      chk($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
      chk($sformatf("row%0d in_ready", i), 32'(in_ready), 32'(tbl[i].ir));
      if (tbl[i].ov)
        chk($sformatf("row%0d out_data", i), out_data, tbl[i].od);
    end

    // Flush while full (TWO in the skid build) with in_valid=1 on the flush edge
    @(negedge clk);
    sel = 2'd0; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    sel = 2'd1;
    @(negedge clk);
    sel = 2'd2; out_ready = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    chk("flush out_valid", 32'(out_valid), 32'd0);
    chk("flush keeps out_data", out_data, A0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post_flush%0d out_valid", i), 32'(out_valid), 32'd0);
    end
    @(negedge clk);
    sel = 2'd3; in_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("recover out_valid", 32'(out_valid), 32'd1);
    chk("recover out_data", out_data, A3);
    @(negedge clk);
    in_valid = 1'b0;

    // Asynchronous reset during a stall
    @(negedge clk);
    sel = 2'd2; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    sel = 2'd1;
    @(posedge clk);
    #1;
    chk("stall out_valid", 32'(out_valid), 32'd1);
    chk("stall out_data", out_data, A2);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst out_valid", 32'(out_valid), 32'd0);
    chk("async rst out_data", out_data, 32'd0);
    chk("async rst out_sel_err", 32'(out_sel_err), 32'd0);
    chk("async rst in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    // N=3: sel=3 yields zero with the error flag for that beat only
    @(negedge clk);
    sel3 = 2'd3; in_valid3 = 1'b1;
    @(posedge clk);
    #1;
    chk("n3 bad out_valid", 32'(out_valid3), 32'd1);
    chk("n3 bad out_data", out_data3, 32'd0);
    chk("n3 bad out_sel_err", 32'(out_sel_err3), 32'd1);
    @(negedge clk);
    sel3 = 2'd1;
    @(posedge clk);
    #1;
    chk("n3 good out_data", out_data3, 32'hFFFFFFFF);
    chk("n3 good out_sel_err", 32'(out_sel_err3), 32'd0);
    @(negedge clk);
    in_valid3 = 1'b0;
    @(posedge clk);
    #1;
    chk("n3 drain out_valid", 32'(out_valid3), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
